// File: rtl/timer_share_ctrl.sv
// Round-robin sharing of one Avalon interval timer among N_REQ one-shot timeout requesters.
// Programs the timer as a write-only master and returns a done pulse to the owner on irq.
module timer_share_ctrl #(
    parameter int N_REQ  = 4,
    parameter int TICK_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*TICK_W-1:0] req_ticks,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic [2:0]              tmr_address,
    output logic                    tmr_chipselect,
    output logic                    tmr_write_n,
    output logic [15:0]             tmr_writedata,
    input  logic                    tmr_irq
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [3:0] {
        IDLE, STOP, WR_PL, WR_PH, CLR, START, WAIT, ACK, CAN_STOP, CAN_CLR
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     owner, rr_ptr, pick, owner_inc;
    logic              found;
    logic [TICK_W-1:0] load, load_nx, tick_sel;
    logic [N_REQ-1:0]  own_oh;
    logic              wr, own_on, dn;
    logic [2:0]        wa;
    logic [15:0]       wd;

    // Circular search starting at the round-robin pointer
    always_comb begin
        logic [IW:0] sum;
        sum   = '0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ))
                sum = sum - (IW+1)'(N_REQ);
            if (!found && req[sum[IW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IW-1:0];
            end
        end
    end

    assign tick_sel  = req_ticks[int'(pick)*TICK_W +: TICK_W];
    assign load_nx   = (tick_sel == '0) ? '0 : tick_sel - 1'b1;
    assign owner_inc = (owner == IW'(N_REQ-1)) ? '0 : owner + 1'b1;
    assign own_oh    = N_REQ'(1) << owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            load   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                owner <= pick;
                load  <= load_nx;
            end
            if (state == ACK || state == CAN_CLR)
                rr_ptr <= owner_inc;
        end
    end

    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        wa       = 3'd0;
        wd       = 16'h0000;
        own_on   = 1'b1;
        dn       = 1'b0;
        unique case (state)
            IDLE: begin
                own_on = 1'b0;
                if (found) state_nx = STOP;
            end
            STOP: begin
                wr = 1'b1; wa = 3'd1; wd = 16'h0008;
                state_nx = WR_PL;
            end
            WR_PL: begin
                wr = 1'b1; wa = 3'd2; wd = load[15:0];
                state_nx = WR_PH;
            end
            WR_PH: begin
                wr = 1'b1; wa = 3'd3; wd = load[31:16];
                state_nx = CLR;
            end
            CLR: begin
                wr = 1'b1;
                state_nx = START;
            end
            START: begin
                wr = 1'b1; wa = 3'd1; wd = 16'h0005;
                state_nx = WAIT;
            end
            WAIT: begin
                // irq wins over a simultaneous cancel
                if (tmr_irq)         state_nx = ACK;
                else if (!req[owner]) state_nx = CAN_STOP;
            end
            ACK: begin
                wr = 1'b1; dn = 1'b1;
                state_nx = IDLE;
            end
            CAN_STOP: begin
                wr = 1'b1; wa = 3'd1; wd = 16'h0008;
                state_nx = CAN_CLR;
            end
            CAN_CLR: begin
                wr = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                own_on   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    assign grant          = own_on ? own_oh : '0;
    assign done           = dn ? own_oh : '0;
    assign busy           = (state != IDLE);
    assign tmr_chipselect = wr;
    assign tmr_write_n    = ~wr;
    assign tmr_address    = wa;
    assign tmr_writedata  = wd;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Bench for timer_share_ctrl: script-queue reference model, timer slave stub,
// directed scenarios with literal expectations and a randomized soak.
module tb_timer_share_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*32-1:0] req_ticks;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [2:0]     tmr_address;
    logic           tmr_chipselect, tmr_write_n;
    logic [15:0]    tmr_writedata;
    logic           tmr_irq;

    always #5 clk = ~clk;

    timer_share_ctrl #(.N_REQ(N), .TICK_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .req_ticks(req_ticks),
        .grant(grant), .done(done), .busy(busy),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_irq(tmr_irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: the owner's remaining bus writes as a script queue
    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        bit          dn;
        bit          last;
    } wr_t;

    wr_t scr[$];
    bit  m_act = 0;
    int  m_own = 0;
    int  m_ptr = 0;

    // Timer slave stub
    bit  t_run = 0;
    bit  t_to = 0;
    int  t_dead = 0;
    int  st_ticks = 0;
    bit  inject_en = 0;
    bit  auto_drop = 1;

    // Observation logs
    int lw_c[$], lw_a[$], lw_d[$];
    int ld_c[$], ld_i[$];
    int svc[$];
    bit bz[int];
    logic [N-1:0] gprev = '0;
    logic [N-1:0] gr_or = '0;

    function automatic wr_t mk(logic [2:0] a, logic [15:0] d, bit dn, bit last);
        wr_t w;
        w.a = a; w.d = d; w.dn = dn; w.last = last;
        return w;
    endfunction

    function automatic logic [N-1:0] m_done_now();
        if (m_act && scr.size() > 0 && scr[0].dn)
            return N'(1) << m_own;
        return '0;
    endfunction

    task automatic clear_logs();
        lw_c.delete(); lw_a.delete(); lw_d.delete();
        ld_c.delete(); ld_i.delete(); svc.delete();
        gr_or = '0;
    endtask

    task automatic step();
        logic [N-1:0] eg, ed;
        logic eb, ecs, ewn;
        logic [2:0] ea;
        logic [15:0] edd;
        wr_t h;
        bit [31:0] t;
        eg = '0; ed = '0; eb = 0; ecs = 0; ewn = 1; ea = 0; edd = 0;
        if (m_act) begin
            eg = N'(1) << m_own;
            eb = 1;
            if (scr.size() > 0) begin
                ecs = 1; ewn = 0; ea = scr[0].a; edd = scr[0].d;
                if (scr[0].dn) ed = eg;
            end
        end
        checks++;
        if ({grant, done, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}
            !== {eg, ed, eb, ecs, ewn, ea, edd}) begin
            errors++;
            if (errors <= 20)
                $display("FAIL cycle %0d outputs: got g=%b d=%b b=%b cs=%b wn=%b a=%0d wd=%h want g=%b d=%b b=%b cs=%b wn=%b a=%0d wd=%h",
                         cyc, grant, done, busy, tmr_chipselect, tmr_write_n, tmr_address,
                         tmr_writedata, eg, ed, eb, ecs, ewn, ea, edd);
        end
        bz[cyc] = busy;
        gr_or |= grant;
        if (grant != '0 && gprev == '0)
            for (int i = 0; i < N; i++)
                if (grant[i]) svc.push_back(i);
        gprev = grant;
        for (int i = 0; i < N; i++)
            if (done[i]) begin ld_c.push_back(cyc); ld_i.push_back(i); end
        // Slave side of any write this cycle
        if (tmr_chipselect && !tmr_write_n) begin
            lw_c.push_back(cyc);
            lw_a.push_back(int'(tmr_address));
            lw_d.push_back(int'(tmr_writedata));
            if (tmr_address == 3'd1 && tmr_writedata[2]) begin
                t_run = 1; t_dead = cyc + st_ticks + 1;
            end else if (tmr_address == 3'd1 && tmr_writedata[3]) begin
                t_run = 0;
            end else if (tmr_address == 3'd0) begin
                t_to = 0;
            end
        end
        if (t_run && cyc >= t_dead) begin t_to = 1; t_run = 0; end
        if (inject_en && !t_run && !m_act && $urandom_range(0, 19) == 0) t_to = 1;
        tmr_irq = t_to;
        // Advance the model with the inputs the DUT samples at the next edge
        if (reset) begin
            m_act = 0; scr.delete(); m_ptr = 0;
        end else if (m_act) begin
            if (scr.size() > 0) begin
                h = scr.pop_front();
                if (h.last) begin m_act = 0; m_ptr = (m_own + 1) % N; end
            end else if (tmr_irq) begin
                scr.push_back(mk(3'd0, 16'h0000, 1, 1));
            end else if (!req[m_own]) begin
                scr.push_back(mk(3'd1, 16'h0008, 0, 0));
                scr.push_back(mk(3'd0, 16'h0000, 0, 1));
            end
        end else if (req != '0) begin
            for (int k = 0; k < N; k++)
                if (!m_act && req[(m_ptr + k) % N]) begin
                    m_act = 1; m_own = (m_ptr + k) % N;
                end
            t = req_ticks[m_own*32 +: 32];
            st_ticks = int'(t);
            if (t != 0) t = t - 1;
            scr.push_back(mk(3'd1, 16'h0008, 0, 0));
            scr.push_back(mk(3'd2, t[15:0], 0, 0));
            scr.push_back(mk(3'd3, t[31:16], 0, 0));
            scr.push_back(mk(3'd0, 16'h0000, 0, 0));
            scr.push_back(mk(3'd1, 16'h0005, 0, 0));
        end
        cyc++;
    endtask

    task automatic tick();
        if (auto_drop) req = req & ~m_done_now();
        step();
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic chk_wr(string nm, int c, logic [2:0] a, logic [15:0] d);
        int idx = -1;
        for (int i = 0; i < lw_c.size(); i++)
            if (lw_c[i] == c) idx = i;
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s: no write at cycle %0d, want (%0d,%h)", nm, c, a, d);
        end else if (lw_a[idx] != int'(a) || lw_d[idx] != int'(d)) begin
            errors++;
            $display("FAIL %s: got (%0d,%h) want (%0d,%h)", nm, lw_a[idx], lw_d[idx], a, d);
        end
    endtask

    function automatic int find_start();
        for (int i = 0; i < lw_c.size(); i++)
            if (lw_a[i] == 1 && lw_d[i] == 5) return lw_c[i];
        return -1;
    endfunction

    task automatic wait_start(string nm, output int s);
        int k = 0;
        while (find_start() < 0 && k < 40) begin tick(); k++; end
        s = find_start();
        chk({nm, "_start_seen"}, 32'(s >= 0), 1);
    endtask

    task automatic wait_done(string nm, int maxc);
        int k = 0;
        while (ld_c.size() == 0 && k < maxc) begin tick(); k++; end
        chk({nm, "_done_seen"}, 32'(ld_c.size() > 0), 1);
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        int t0, s, d, r, n;
        reset = 1; req = '0; req_ticks = '0; tmr_irq = 0;
        @(negedge clk);
        // Reset state
        chk("rst_grant", 32'(grant), 0);
        chk("rst_bus", {busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {1'b0, 1'b0, 1'b1, 3'd0, 16'h0000});
        tick(); reset = 0; run(2);

        // Single requester, ticks=10
        clear_logs();
        req_ticks[0 +: 32] = 32'd10; req = 4'b0001; t0 = cyc;
        wait_done("t1", 60);
        chk_wr("t1_stop", t0 + 1, 3'd1, 16'h0008);
        chk_wr("t1_pl", t0 + 2, 3'd2, 16'h0009);
        chk_wr("t1_ph", t0 + 3, 3'd3, 16'h0000);
        chk_wr("t1_clr", t0 + 4, 3'd0, 16'h0000);
        chk_wr("t1_start", t0 + 5, 3'd1, 16'h0005);
        if (ld_c.size() > 0) chk("t1_done_lat", 32'(ld_c[0] - (t0 + 5)), 12);
        chk("t1_grant", 32'(gr_or), 32'h1);
        run(3);

        // Round-robin fairness with everyone held
        do_reset(); clear_logs();
        auto_drop = 0;
        for (int i = 0; i < N; i++) req_ticks[i*32 +: 32] = 32'd3;
        req = 4'b1111; n = 0;
        while (svc.size() < 5 && n < 200) begin tick(); n++; end
        chk("t2_count", 32'(svc.size() >= 5), 1);
        if (svc.size() >= 5) begin
            chk("t2_svc0", 32'(svc[0]), 0);
            chk("t2_svc1", 32'(svc[1]), 1);
            chk("t2_svc2", 32'(svc[2]), 2);
            chk("t2_svc3", 32'(svc[3]), 3);
            chk("t2_svc4", 32'(svc[4]), 0);
        end
        req = '0; auto_drop = 1; run(20);

        // Cancel after 50 cycles of WAIT
        clear_logs();
        req_ticks[2*32 +: 32] = 32'd1000; req = 4'b0100;
        wait_start("t3", s);
        run_to(s + 50);
        req = 4'b0000; d = cyc;
        run(6);
        chk_wr("t3_can_stop", d + 1, 3'd1, 16'h0008);
        chk_wr("t3_can_clr", d + 2, 3'd0, 16'h0000);
        chk("t3_no_done", 32'(ld_c.size()), 0);
        chk("t3_busy", 32'(bz[d + 3]), 0);

        // ticks=0 -> load 0, done at START+2
        clear_logs();
        req_ticks[1*32 +: 32] = 32'd0; req = 4'b0010; t0 = cyc;
        wait_done("t4a", 40);
        chk_wr("t4a_pl", t0 + 2, 3'd2, 16'h0000);
        chk_wr("t4a_ph", t0 + 3, 3'd3, 16'h0000);
        if (ld_c.size() > 0) chk("t4a_done_lat", 32'(ld_c[0] - (t0 + 5)), 2);
        run(3);

        // ticks=0x00010000 -> PL=FFFF, PH=0000
        clear_logs();
        req_ticks[3*32 +: 32] = 32'h0001_0000; req = 4'b1000; t0 = cyc;
        run(8);
        chk_wr("t4b_pl", t0 + 2, 3'd2, 16'hFFFF);
        chk_wr("t4b_ph", t0 + 3, 3'd3, 16'h0000);
        req = '0; run(6);

        // Drop req in the same cycle irq rises
        clear_logs();
        req_ticks[0 +: 32] = 32'd5; req = 4'b0001;
        wait_start("t5", s);
        run_to(s + 6);
        req = 4'b0000;
        run(6);
        chk("t5_ndone", 32'(ld_c.size()), 1);
        if (ld_c.size() > 0) chk("t5_done_cyc", 32'(ld_c[0]), 32'(s + 7));
        chk_wr("t5_ack", s + 7, 3'd0, 16'h0000);
        n = 0;
        foreach (lw_c[i]) if (lw_c[i] > s) n++;
        chk("t5_writes_after_start", 32'(n), 1);

        // Reset in WAIT, then restart with the request still held
        clear_logs();
        req_ticks[2*32 +: 32] = 32'd20; req = 4'b0100;
        wait_start("t6", s);
        run_to(s + 3);
        reset = 1; tick(); reset = 0; r = cyc;
        chk("t6_rst_outs",
            {28'(grant), busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {28'd0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("t6_rst_done", 32'(done), 0);
        ld_c.delete(); ld_i.delete();
        wait_done("t6", 60);
        chk_wr("t6_restart", r + 1, 3'd1, 16'h0008);
        chk_wr("t6_start", r + 5, 3'd1, 16'h0005);
        run(4);

        // Randomized soak against the model
        inject_en = 1; auto_drop = 0;
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] dn;
            dn = m_done_now();
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 9) == 0) begin
                        case ($urandom_range(0, 3))
                            0: req_ticks[i*32 +: 32] = 32'd0;
                            1: req_ticks[i*32 +: 32] = 32'd1;
                            default: req_ticks[i*32 +: 32] = 32'($urandom_range(2, 25));
                        endcase
                        req[i] = 1'b1;
                    end
                end else if (dn[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 79) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 19) == 0)
                    req_ticks[i*32 +: 32] = 32'($urandom_range(0, 25));
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0; req = '0; inject_en = 0;
        run(100);
        chk("end_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
